// File: rtl/m65c02_bus_fabric.sv
`default_nettype none
// ============================================================================
// Module   : m65c02_bus_fabric
// Purpose  : M65C02 memory-mapped interconnect. It provides base/mask decode,
//            wait states, a ready handshake, a bus timeout and a registered
//            read mux. Optional trace port enabled by `define BUS_TRACE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module m65c02_bus_fabric #(
    parameter int                             NUM_SLAVES     = 8,
    parameter int                             DATA_WIDTH     = 8,
    parameter int                             ADDR_WIDTH     = 16,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE   = '0,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK   = '0,
    parameter logic [NUM_SLAVES*4-1:0]        SLAVE_WAIT     = '0,
    parameter int                             TIMEOUT_CYCLES = 64,
    parameter logic [DATA_WIDTH-1:0]          UNMAPPED_DATA  = 8'hFF,
    parameter logic [DATA_WIDTH-1:0]          RESET_DATA     = 8'hEA
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [ADDR_WIDTH-1:0]            cpu_addr,
    input  logic [1:0]                       cpu_io_op,
    input  logic [2:0]                       cpu_mc,
    input  logic [DATA_WIDTH-1:0]            cpu_dout,
    output logic [DATA_WIDTH-1:0]            cpu_din,
    output logic                             cpu_wait,
    output logic [NUM_SLAVES-1:0]            slave_sel,
    output logic [NUM_SLAVES-1:0]            slave_we,
    output logic [NUM_SLAVES-1:0]            slave_rd,
    output logic [DATA_WIDTH-1:0]            slave_wdata,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] slave_rdata,
    input  logic [NUM_SLAVES-1:0]            slave_ready,
    output logic                             bus_err,
    output logic [ADDR_WIDTH-1:0]            bus_err_addr,
    output logic [ADDR_WIDTH-1:0]            dbg_addr,
    output logic [DATA_WIDTH-1:0]            dbg_data,
    output logic                             dbg_we,
    output logic                             dbg_valid
);

    localparam int IDXW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int TMOW = $clog2(TIMEOUT_CYCLES);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [TMOW-1:0]       tmo_q, tmo_d;
    logic [IDXW-1:0]       idx_q, idx_d;
    logic                  to_hit_q, to_hit_d;
    logic                  wr_q, wr_d;
    logic [DATA_WIDTH-1:0] cpu_din_q, cpu_din_d;
    logic                  bus_err_q, bus_err_d;
    logic [ADDR_WIDTH-1:0] bus_err_addr_q, bus_err_addr_d;

    logic [NUM_SLAVES-1:0] w_hit;
    logic [NUM_SLAVES-1:0] w_sel;
    logic                  w_mapped;
    logic [IDXW-1:0]       w_win;
    logic [3:0]            w_win_wait;
    logic                  w_win_ready;
    logic [DATA_WIDTH-1:0] w_win_rdata;
    logic                  w_idx_ready;
    logic                  w_acc_start;
    logic                  w_cap;
    logic [DATA_WIDTH-1:0] w_mux;

    generate
        for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_dec
            assign w_hit[i] = ((cpu_addr & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH])
                               == SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH])
                              && (|SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]);
        end
    endgenerate

    // Priority pick of the lowest hitting index, plus the per-winner and
    // per-latched-index attributes, resolved without variable part-selects.
    always_comb begin
        w_mapped    = 1'b0;
        w_sel       = '0;
        w_win       = '0;
        w_win_wait  = '0;
        w_win_ready = 1'b0;
        w_win_rdata = '0;
        w_idx_ready = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (w_hit[i] && !w_mapped) begin
                w_mapped    = 1'b1;
                w_sel[i]    = 1'b1;
                w_win       = IDXW'(i);
                w_win_wait  = SLAVE_WAIT[i*4 +: 4];
                w_win_ready = slave_ready[i];
                w_win_rdata = slave_rdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
            if (IDXW'(i) == idx_q) begin
                w_idx_ready = slave_ready[i];
            end
        end
    end

    assign w_acc_start = (state_q == ST_IDLE) && (cpu_mc == 3'b111) && (cpu_io_op != 2'b00);
    assign w_cap       = (cpu_mc == 3'b101) && (state_q != ST_WAIT);
    assign w_mux       = (!w_mapped || to_hit_q) ? UNMAPPED_DATA : w_win_rdata;

    assign slave_sel   = w_sel;
    assign slave_we    = (w_acc_start && cpu_io_op == 2'b01) ? w_sel : '0;
    assign slave_rd    = (w_acc_start && cpu_io_op != 2'b01) ? w_sel : '0;
    assign slave_wdata = cpu_dout;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        tmo_d          = tmo_q;
        idx_d          = idx_q;
        to_hit_d       = to_hit_q;
        wr_d           = wr_q;
        cpu_din_d      = cpu_din_q;
        bus_err_d      = bus_err_q;
        bus_err_addr_d = bus_err_addr_q;

        if (state_q == ST_IDLE) begin
            if (cpu_mc == 3'b111) begin
                wr_d = (cpu_io_op == 2'b01);
            end
            if (w_acc_start && w_mapped && (w_win_wait != 4'd0 || !w_win_ready)) begin
                state_d = ST_WAIT;
                cnt_d   = w_win_wait;
                tmo_d   = '0;
                idx_d   = w_win;
            end
        end else begin
            cnt_d = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
            tmo_d = tmo_q + TMOW'(1);
            // Normal completion takes priority when it coincides with the limit.
            if (cnt_q == 4'd0 && w_idx_ready) begin
                state_d = ST_IDLE;
            end else if (tmo_q == TMOW'(TIMEOUT_CYCLES - 1)) begin
                state_d   = ST_IDLE;
                to_hit_d  = 1'b1;
                bus_err_d = 1'b1;
                if (!bus_err_q) begin
                    bus_err_addr_d = cpu_addr;
                end
            end
        end

        if (w_cap) begin
            to_hit_d = 1'b0;
            if (!wr_q) begin
                cpu_din_d = w_mux;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            tmo_q          <= '0;
            idx_q          <= '0;
            to_hit_q       <= 1'b0;
            wr_q           <= 1'b0;
            cpu_din_q      <= RESET_DATA;
            bus_err_q      <= 1'b0;
            bus_err_addr_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            tmo_q          <= tmo_d;
            idx_q          <= idx_d;
            to_hit_q       <= to_hit_d;
            wr_q           <= wr_d;
            cpu_din_q      <= cpu_din_d;
            bus_err_q      <= bus_err_d;
            bus_err_addr_q <= bus_err_addr_d;
        end
    end

    assign cpu_wait     = (state_q == ST_WAIT);
    assign cpu_din      = cpu_din_q;
    assign bus_err      = bus_err_q;
    assign bus_err_addr = bus_err_addr_q;

`ifdef BUS_TRACE_EN
    logic                  pend_q, pend_d;
    logic [ADDR_WIDTH-1:0] dbg_addr_q, dbg_addr_d;
    logic [DATA_WIDTH-1:0] dbg_data_q, dbg_data_d;
    logic                  dbg_we_q, dbg_we_d;
    logic                  dbg_valid_q, dbg_valid_d;

    // An access completes on the first unstalled MC=5 edge after it started.
    always_comb begin
        pend_d      = pend_q;
        dbg_addr_d  = dbg_addr_q;
        dbg_data_d  = dbg_data_q;
        dbg_we_d    = dbg_we_q;
        dbg_valid_d = 1'b0;
        if (w_acc_start) begin
            pend_d = 1'b1;
        end else if (w_cap && pend_q) begin
            pend_d      = 1'b0;
            dbg_valid_d = 1'b1;
            dbg_addr_d  = cpu_addr;
            dbg_data_d  = wr_q ? cpu_dout : w_mux;
            dbg_we_d    = wr_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q      <= 1'b0;
            dbg_addr_q  <= '0;
            dbg_data_q  <= '0;
            dbg_we_q    <= 1'b0;
            dbg_valid_q <= 1'b0;
        end else begin
            pend_q      <= pend_d;
            dbg_addr_q  <= dbg_addr_d;
            dbg_data_q  <= dbg_data_d;
            dbg_we_q    <= dbg_we_d;
            dbg_valid_q <= dbg_valid_d;
        end
    end

    assign dbg_addr  = dbg_addr_q;
    assign dbg_data  = dbg_data_q;
    assign dbg_we    = dbg_we_q;
    assign dbg_valid = dbg_valid_q;
`else
    assign dbg_addr  = '0;
    assign dbg_data  = '0;
    assign dbg_we    = 1'b0;
    assign dbg_valid = 1'b0;
`endif

endmodule
`default_nettype wire
